// File: rtl/knob_pkg.sv
// knob_pkg: shared phase type, Gray-code order and error-counter width for the quadrature decoder
package knob_pkg;
   typedef logic [1:0] phase_t;
   localparam phase_t PH_00 = 2'b00;
   localparam phase_t PH_01 = 2'b01;
   localparam phase_t PH_11 = 2'b11;
   localparam phase_t PH_10 = 2'b10;
   localparam int ERRW = 8;
   function automatic phase_t cw_next(phase_t p);
      return p == PH_00 ? PH_01 : p == PH_01 ? PH_11 : p == PH_11 ? PH_10 : PH_00;
   endfunction
endpackage

// File: rtl/knob_decoder_if.sv
// knob_decoder_if: raw quadrature phases in, notch pulses out; err_count only with KNOB_DECODER_ERRCNT_EN
interface knob_decoder_if;
   import knob_pkg::*;
   logic qa, qb, up, down, error;
`ifdef KNOB_DECODER_ERRCNT_EN
   logic [ERRW-1:0] err_count;
   modport master(output qa, qb, input up, down, error, err_count);
   modport slave(input qa, qb, output up, down, error, err_count);
`else
   modport master(output qa, qb, input up, down, error);
   modport slave(input qa, qb, output up, down, error);
`endif
endinterface

// File: rtl/knob_debounce.sv
// knob_debounce: synchroniser chain plus stability filter for one quadrature phase
module knob_debounce #(
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 3
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   input  logic prime,
   output logic s,
   output logic f
);
   localparam int CW = $clog2(DEBOUNCE + 1);
   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0] cnt;
   logic hit;
   assign s = sync[SYNC_STAGES-1];
   assign hit = s != f && cnt == CW'(DEBOUNCE - 1);
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync <= '0;
         f    <= 1'b0;
         cnt  <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], d};
         f    <= (prime || hit) ? s : f;
         cnt  <= (prime || s == f || hit) ? '0 : cnt + CW'(1);
      end
   end
endmodule

// File: rtl/knob_decoder.sv
// knob_decoder: quadrature phases to one-cycle up/down notch pulses with illegal-jump flag
module knob_decoder
   import knob_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE        = 3,
   parameter int STEPS_PER_NOTCH = 4
) (
   input logic clock,
   input logic reset,
   knob_decoder_if.slave bus
);
   localparam logic signed [4:0] LIM = 5'(STEPS_PER_NOTCH);
   logic sa, sb, fa, fb, primed, illegal;
   logic up_q, down_q, err_q, up_n, down_n, err_n;
   logic [SYNC_STAGES:0] warm;
   phase_t prev, prev_n, cur;
   logic signed [4:0] acc, acc_n, step, sum;
   assign primed = warm[SYNC_STAGES];
   knob_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE)) u_a (
      .clock(clock), .reset(reset), .d(bus.qa), .prime(!primed), .s(sa), .f(fa));
   knob_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE)) u_b (
      .clock(clock), .reset(reset), .d(bus.qb), .prime(!primed), .s(sb), .f(fb));
   always_comb begin
      cur     = {fa, fb};
      prev_n  = primed ? cur : {sa, sb};
      illegal = primed && (cur ^ prev) == 2'b11;
      step    = (!primed || illegal) ? 5'sd0 : cur == cw_next(prev) ? 5'sd1 :
                prev == cw_next(cur) ? -5'sd1 : 5'sd0;
      sum     = acc + step;
      up_n    = sum == LIM;
      down_n  = sum == -LIM;
      err_n   = illegal;
      acc_n   = (illegal || up_n || down_n) ? 5'sd0 : sum;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         warm   <= '0;
         prev   <= PH_00;
         acc    <= '0;
         up_q   <= 1'b0;
         down_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         warm   <= {warm[SYNC_STAGES-1:0], 1'b1};
         prev   <= prev_n;
         acc    <= acc_n;
         up_q   <= up_n;
         down_q <= down_n;
         err_q  <= err_n;
      end
   end
   assign bus.up    = up_q;
   assign bus.down  = down_q;
   assign bus.error = err_q;
`ifdef KNOB_DECODER_ERRCNT_EN
   logic [ERRW-1:0] errcnt;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) errcnt <= '0;
      else errcnt <= errcnt + ERRW'(err_n && errcnt != '1);
   end
   assign bus.err_count = errcnt;
`endif
endmodule
